alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_comb.sv | 51 +++++
 rtl/alu_seq.sv | 152 +++++++++++++++
 tb/tb_alu_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state constants and multiplier iteration count for the
// sequential ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_ADC  = 4'h1,
        OP_SUB  = 4'h2,
        OP_SBB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_NOT  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_INC  = 4'hA,
        OP_DEC  = 4'hB,
        OP_PASS = 4'hC,
        OP_MUL  = 4'hD
    } op_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EXEC = 2'd1;
    localparam state_t ST_MUL  = 2'd2;

    localparam int unsigned MUL_ITER = 8;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle arithmetic/logic for the sequential ALU. Reserved opcodes (and MUL,
// which is handled in alu_seq) pass A through with a cleared carry.
module alu_comb
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cy_in,
    output logic [7:0] res,
    output logic       cy
);

    always_comb begin
        res = a;
        cy  = 1'b0;
        case (op)
            OP_ADD:  {cy, res} = {1'b0, a} + {1'b0, b};
            OP_ADC:  {cy, res} = {1'b0, a} + {1'b0, b} + {8'd0, cy_in};
            // Bit 8 of the 9-bit difference is the borrow.
            OP_SUB:  {cy, res} = {1'b0, a} - {1'b0, b};
            OP_SBB:  {cy, res} = {1'b0, a} - {1'b0, b} - {8'd0, cy_in};
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL: begin
                res = {a[6:0], 1'b0};
                cy  = a[7];
            end
            OP_SHR: begin
                res = {1'b0, a[7:1]};
                cy  = a[0];
            end
            OP_INC: begin
                res = a + 8'd1;
                cy  = (a == 8'hFF);
            end
            OP_DEC: begin
                res = a - 8'd1;
                cy  = (a == 8'h00);
            end
            OP_PASS: res = b;
            default: begin
                res = a;
                cy  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: latches an operation on START, completes in EXEC (1 cycle) or via an
// 8-step shift-add multiply when built with `define ALU_SEQ_MUL_EN.
module alu_seq
    import alu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] OP,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CY_IN,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] ALU_RESULT,
    output logic       ALU_CY
);

    state_t     state_q, state_d;
    logic [3:0] op_q;
    logic [7:0] a_q, b_q;
    logic       cy_in_q;
    logic       done_q;
    logic [7:0] res_q;
    logic       res_cy_q;

    logic [7:0] comb_res;
    logic       comb_cy;
    logic [7:0] fin_res;
    logic       fin_cy;
    logic       accept;

    assign accept = (state_q == ST_IDLE) && START;

    alu_comb u_alu_comb (
        .op    (op_q),
        .a     (a_q),
        .b     (b_q),
        .cy_in (cy_in_q),
        .res   (comb_res),
        .cy    (comb_cy)
    );

`ifdef ALU_SEQ_MUL_EN
    localparam logic [2:0] CntLast = 3'(MUL_ITER - 1);

    logic [15:0] acc_q, acc_d;
    logic [2:0]  cnt_q;

    // One multiplier bit per cycle, LSB first.
    always_comb begin
        acc_d = acc_q;
        if (b_q[cnt_q]) begin
            acc_d = acc_q + ({8'd0, a_q} << cnt_q);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q <= 16'd0;
            cnt_q <= 3'd0;
        end else if (accept) begin
            acc_q <= 16'd0;
            cnt_q <= 3'd0;
        end else if (state_q == ST_MUL) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 3'd1;
        end
    end

    // A finished multiply drains through EXEC, which registers the product.
    always_comb begin
        fin_res = comb_res;
        fin_cy  = comb_cy;
        if (op_q == OP_MUL) begin
            fin_res = acc_q[7:0];
            fin_cy  = |acc_q[15:8];
        end
    end
`else
    always_comb begin
        fin_res = comb_res;
        fin_cy  = comb_cy;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
`ifdef ALU_SEQ_MUL_EN
                    state_d = (OP == OP_MUL) ? ST_MUL : ST_EXEC;
`else
                    state_d = ST_EXEC;
`endif
                end
            end
            ST_EXEC: state_d = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (cnt_q == CntLast) begin
                    state_d = ST_EXEC;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_q    <= 4'd0;
            a_q     <= 8'd0;
            b_q     <= 8'd0;
            cy_in_q <= 1'b0;
        end else if (accept) begin
            op_q    <= OP;
            a_q     <= A;
            b_q     <= B;
            cy_in_q <= CY_IN;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_q   <= 1'b0;
            res_q    <= 8'd0;
            res_cy_q <= 1'b0;
        end else begin
            done_q <= (state_q == ST_EXEC);
            if (state_q == ST_EXEC) begin
                res_q    <= fin_res;
                res_cy_q <= fin_cy;
            end
        end
    end

    assign BUSY       = (state_q != ST_IDLE);
    assign DONE       = done_q;
    assign ALU_RESULT = res_q;
    assign ALU_CY     = res_cy_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: per-cycle comparison against an arithmetic model plus
// directed literal cases; multiply expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN  = 1'b1;
    localparam int MUL_LAT = 9;
`else
    localparam bit MUL_EN  = 1'b0;
    localparam int MUL_LAT = 1;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [3:0] OP;
    logic [7:0] A;
    logic [7:0] B;
    logic       CY_IN;
    logic       BUSY;
    logic       DONE;
    logic [7:0] ALU_RESULT;
    logic       ALU_CY;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    alu_seq dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .OP         (OP),
        .A          (A),
        .B          (B),
        .CY_IN      (CY_IN),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .ALU_RESULT (ALU_RESULT),
        .ALU_CY     (ALU_CY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {carry, result} from the opcode table using plain integer arithmetic.
    function automatic logic [8:0] ref_op(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        int ai, bi, ci, r;
        logic k;
        ai = int'(a);
        bi = int'(b);
        ci = int'(c);
        k  = 1'b0;
        case (op)
            4'h0: begin r = ai + bi;      k = (r > 255); end
            4'h1: begin r = ai + bi + ci; k = (r > 255); end
            4'h2: begin r = ai - bi;      k = (r < 0);   end
            4'h3: begin r = ai - bi - ci; k = (r < 0);   end
            4'h4: r = ai & bi;
            4'h5: r = ai | bi;
            4'h6: r = ai ^ bi;
            4'h7: r = 255 - ai;
            4'h8: begin r = ai * 2;  k = (ai >= 128); end
            4'h9: begin r = ai / 2;  k = (ai % 2 == 1); end
            4'hA: begin r = ai + 1;  k = (ai == 255); end
            4'hB: begin r = ai - 1;  k = (ai == 0);   end
            4'hC: r = bi;
            4'hD: begin
                if (MUL_EN) begin
                    r = ai * bi;
                    k = (r > 255);
                end else begin
                    r = ai;
                end
            end
            default: r = ai;
        endcase
        return {k, 8'(r & 255)};
    endfunction

    // Model: cycles left until the result appears, and the pending result.
    int         m_left;
    logic       m_done;
    logic [7:0] m_res, m_pres;
    logic       m_cy, m_pcy;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= 8'h00;
            m_cy   <= 1'b0;
            m_pres <= 8'h00;
            m_pcy  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (START) begin
                    {m_pcy, m_pres} <= ref_op(OP, A, B, CY_IN);
                    m_left <= (MUL_EN && OP == 4'hD) ? 9 : 1;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pres;
                    m_cy   <= m_pcy;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("busy", int'(BUSY), int'(m_left != 0));
            chk("done", int'(DONE), int'(m_done));
            chk("result", int'(ALU_RESULT), int'(m_res));
            chk("carry", int'(ALU_CY), int'(m_cy));
        end
    end

    // Issue one op (inputs change 2 time units after a rising edge) and check latency and
    // literal result. With now=1 START is raised in the current cycle without waiting.
    task automatic do_op(input string name, input bit now, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b, input logic c,
                         input int exp_lat, input logic [7:0] er, input logic ec);
        int lat;
        if (!now) begin
            @(posedge CLK);
            #2;
        end
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        CY_IN = c;
        @(posedge CLK);
        #2;
        START = 1'b0;
        lat   = 0;
        while (!DONE && lat < 30) begin
            @(posedge CLK);
            #2;
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, int'(ALU_RESULT), int'(er));
        chk({name, " carry"}, int'(ALU_CY), int'(ec));
    endtask

    initial begin
        int dones;
        START = 1'b0;
        OP    = 4'h0;
        A     = 8'h00;
        B     = 8'h00;
        CY_IN = 1'b0;
        RST   = 1'b0;
        #1 RST = 1'b1;
        repeat (3) @(posedge CLK);
        #2;
        chk("reset busy", int'(BUSY), 0);
        chk("reset done", int'(DONE), 0);
        chk("reset result", int'(ALU_RESULT), 8'h00);
        chk("reset carry", int'(ALU_CY), 0);
        RST    = 1'b0;
        chk_en = 1'b1;

        // First START right after reset release.
        do_op("add_f0_20", 1'b1, 4'h0, 8'hF0, 8'h20, 1'b0, 1, 8'h10, 1'b1);
        do_op("sbb_05_05", 1'b0, 4'h3, 8'h05, 8'h05, 1'b1, 1, 8'hFF, 1'b1);
        do_op("sub_05_03", 1'b0, 4'h2, 8'h05, 8'h03, 1'b0, 1, 8'h02, 1'b0);
        do_op("inc_ff", 1'b0, 4'hA, 8'hFF, 8'h00, 1'b0, 1, 8'h00, 1'b1);
        do_op("dec_00", 1'b0, 4'hB, 8'h00, 8'h00, 1'b0, 1, 8'hFF, 1'b1);
        do_op("shr_81", 1'b0, 4'h9, 8'h81, 8'h00, 1'b0, 1, 8'h40, 1'b1);
        do_op("shl_80", 1'b0, 4'h8, 8'h80, 8'h00, 1'b0, 1, 8'h00, 1'b1);
        do_op("not_0f", 1'b0, 4'h7, 8'h0F, 8'h00, 1'b0, 1, 8'hF0, 1'b0);
        do_op("adc_ff_00", 1'b0, 4'h1, 8'hFF, 8'h00, 1'b1, 1, 8'h00, 1'b1);
        do_op("xor_a5_ff", 1'b0, 4'h6, 8'hA5, 8'hFF, 1'b1, 1, 8'h5A, 1'b0);
        do_op("pass_b", 1'b0, 4'hC, 8'h11, 8'h77, 1'b1, 1, 8'h77, 1'b0);
        do_op("rsvd_e", 1'b0, 4'hE, 8'h5A, 8'h33, 1'b1, 1, 8'h5A, 1'b0);
`ifdef ALU_SEQ_MUL_EN
        do_op("mul_10_20", 1'b0, 4'hD, 8'h10, 8'h20, 1'b0, 9, 8'h00, 1'b1);
        do_op("mul_0c_0d", 1'b0, 4'hD, 8'h0C, 8'h0D, 1'b0, 9, 8'h9C, 1'b0);
`else
        do_op("mul_10_20", 1'b0, 4'hD, 8'h10, 8'h20, 1'b0, 1, 8'h10, 1'b0);
        do_op("mul_0c_0d", 1'b0, 4'hD, 8'h0C, 8'h0D, 1'b0, 1, 8'h0C, 1'b0);
`endif
        // Back-to-back: START raised in the DONE cycle of the previous op.
        do_op("b2b_add", 1'b1, 4'h0, 8'h01, 8'h02, 1'b0, 1, 8'h03, 1'b0);

        // START pulses while busy must be dropped: exactly one DONE.
        @(posedge CLK);
        #2;
        START = 1'b1;
        OP    = 4'hD;
        A     = 8'h03;
        B     = 8'h05;
        @(posedge CLK);
        #2;
        START = !MUL_EN;
        OP    = 4'h0;
        dones = 0;
        for (int i = 1; i <= MUL_LAT + 6; i++) begin
            @(posedge CLK);
            #2;
            if (DONE) dones++;
            START = MUL_EN && (i == 2 || i == 4);
        end
        START = 1'b0;
        chk("busy_ignore dones", dones, 1);

        // Reset in the middle of an operation aborts it.
        @(posedge CLK);
        #2;
        START = 1'b1;
        OP    = 4'hD;
        A     = 8'hFF;
        B     = 8'hFF;
        @(posedge CLK);
        #2;
        START = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b1;
        @(posedge CLK);
        #2;
        RST   = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #2;
            if (DONE) dones++;
        end
        chk("abort dones", dones, 0);
        chk("abort result", int'(ALU_RESULT), 8'h00);
        chk("abort carry", int'(ALU_CY), 0);

        // Random traffic, including START noise while busy and rare resets.
        for (int i = 0; i < 1500; i++) begin
            @(posedge CLK);
            #2;
            RST   = ($urandom_range(0, 199) == 0);
            START = ($urandom_range(0, 2) != 0);
            OP    = 4'($urandom_range(0, 15));
            A     = 8'($urandom);
            B     = 8'($urandom);
            CY_IN = 1'($urandom);
        end
        RST   = 1'b0;
        START = 1'b0;
        repeat (12) @(posedge CLK);
        #2;
        chk("final idle", int'(BUSY), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
